// File: rtl/execute_stage_pkg.sv
// execute_stage_pkg: opcode-class and ALU-op one-hot indices shared by decode and execute.
package execute_stage_pkg;
    localparam int OPCODE_WIDTH = 11;
    localparam int ALU_WIDTH    = 14;

    localparam int OP_RTYPE  = 0;
    localparam int OP_ITYPE  = 1;
    localparam int OP_LOAD   = 2;
    localparam int OP_STORE  = 3;
    localparam int OP_BRANCH = 4;
    localparam int OP_JAL    = 5;
    localparam int OP_JALR   = 6;
    localparam int OP_LUI    = 7;
    localparam int OP_AUIPC  = 8;
    localparam int OP_SYSTEM = 9;
    localparam int OP_FENCE  = 10;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_XOR  = 4;
    localparam int ALU_OR   = 5;
    localparam int ALU_AND  = 6;
    localparam int ALU_SLL  = 7;
    localparam int ALU_SRL  = 8;
    localparam int ALU_SRA  = 9;
    localparam int ALU_EQ   = 10;
    localparam int ALU_NEQ  = 11;
    localparam int ALU_GE   = 12;
    localparam int ALU_GEU  = 13;

    // Classes that write rd: RTYPE, ITYPE, LOAD, JAL, JALR, LUI, AUIPC
    localparam logic [OPCODE_WIDTH-1:0] WR_RD_MASK = 11'b001_1110_0111;
endpackage

// File: rtl/execute_stage_alu.sv
// alu: combinational RV32I ALU; compares yield 0/1 in o_y and also drive o_cmp.
module alu
    import execute_stage_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0]    i_a,
    input  logic [DWIDTH-1:0]    i_b,
    input  logic [ALU_WIDTH-1:0] i_op,
    output logic [DWIDTH-1:0]    o_y,
    output logic                 o_cmp
);
    logic [4:0] w_sh;
    logic       w_lt;
    logic       w_ltu;
    logic       w_eq;
    logic       w_c;

    assign w_sh  = i_b[4:0];
    assign w_lt  = $signed(i_a) < $signed(i_b);
    assign w_ltu = i_a < i_b;
    assign w_eq  = i_a == i_b;
    assign w_c   = i_op[ALU_SLT]  ? w_lt   :
                   i_op[ALU_SLTU] ? w_ltu  :
                   i_op[ALU_EQ]   ? w_eq   :
                   i_op[ALU_NEQ]  ? ~w_eq  :
                   i_op[ALU_GE]   ? ~w_lt  :
                   i_op[ALU_GEU]  ? ~w_ltu : 1'b0;
    assign o_cmp = w_c;
    assign o_y   = i_op[ALU_ADD] ? i_a + i_b :
                   i_op[ALU_SUB] ? i_a - i_b :
                   i_op[ALU_XOR] ? i_a ^ i_b :
                   i_op[ALU_OR]  ? i_a | i_b :
                   i_op[ALU_AND] ? i_a & i_b :
                   i_op[ALU_SLL] ? i_a << w_sh :
                   i_op[ALU_SRL] ? i_a >> w_sh :
                   i_op[ALU_SRA] ? DWIDTH'($signed(i_a) >>> w_sh) :
                   {{(DWIDTH-1){1'b0}}, w_c};
endmodule

// File: rtl/execute_stage.sv
// execute_stage: RV32I execute with operand/result muxing, branch resolution
// and a registered EX/MEM boundary with stall, flush and redirect control.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int DWIDTH      = 32,
    parameter int PC_WIDTH    = 32,
    parameter int AWIDTH      = 5,
    parameter int FUNCT_WIDTH = 3
) (
    input  logic                    c_clk,
    input  logic                    c_rst,
    input  logic                    ex_i_ce,
    input  logic                    ex_i_valid,
    input  logic                    ex_i_stall,
    input  logic                    ex_i_flush,
    input  logic [PC_WIDTH-1:0]     ex_i_pc,
    input  logic [OPCODE_WIDTH-1:0] ex_i_opcode,
    input  logic [ALU_WIDTH-1:0]    ex_i_alu,
    input  logic [FUNCT_WIDTH-1:0]  ex_i_funct3,
    input  logic [DWIDTH-1:0]       ex_i_imm,
    input  logic [AWIDTH-1:0]       ex_i_addr_rd,
    input  logic [DWIDTH-1:0]       ex_i_data_rs1,
    input  logic [DWIDTH-1:0]       ex_i_data_rs2,
    output logic                    ex_o_valid,
    output logic [DWIDTH-1:0]       ex_o_result,
    output logic [DWIDTH-1:0]       ex_o_store_data,
    output logic [AWIDTH-1:0]       ex_o_addr_rd,
    output logic                    ex_o_wr_rd,
    output logic [OPCODE_WIDTH-1:0] ex_o_opcode,
    output logic [FUNCT_WIDTH-1:0]  ex_o_funct3,
    output logic                    ex_o_change_pc,
    output logic [PC_WIDTH-1:0]     ex_o_next_pc,
    output logic                    ex_o_flush,
    output logic                    ex_o_stall
);
    logic [DWIDTH-1:0] w_a, w_b, w_y, w_sum, w_pc4, w_result;
    logic [PC_WIDTH-1:0] w_target;
    logic w_cmp, w_adv, w_live, w_taken, w_wr;
    logic [DWIDTH-1:0] r_result, r_store_data;
    logic [AWIDTH-1:0] r_addr_rd;
    logic [OPCODE_WIDTH-1:0] r_opcode;
    logic [FUNCT_WIDTH-1:0] r_funct3;
    logic [PC_WIDTH-1:0] r_next_pc;
    logic r_valid, r_wr_rd, r_change_pc, r_flush;

    alu #(.DWIDTH(DWIDTH)) u_alu (.i_a(w_a), .i_b(w_b), .i_op(ex_i_alu), .o_y(w_y), .o_cmp(w_cmp));

    assign w_a      = (ex_i_opcode[OP_AUIPC] | ex_i_opcode[OP_JAL]) ? DWIDTH'(ex_i_pc) : ex_i_data_rs1;
    assign w_b      = (ex_i_opcode[OP_RTYPE] | ex_i_opcode[OP_BRANCH]) ? ex_i_data_rs2 : ex_i_imm;
    assign w_sum    = ex_i_data_rs1 + ex_i_imm;
    assign w_pc4    = DWIDTH'(ex_i_pc) + DWIDTH'(4);
    assign w_result = ex_i_opcode[OP_LUI] ? ex_i_imm :
                      (ex_i_opcode[OP_JAL] | ex_i_opcode[OP_JALR]) ? w_pc4 :
                      (ex_i_opcode[OP_LOAD] | ex_i_opcode[OP_STORE]) ? w_sum : w_y;
    assign w_target = ex_i_opcode[OP_JALR] ? PC_WIDTH'(w_sum & ~DWIDTH'(1)) : ex_i_pc + PC_WIDTH'(ex_i_imm);
    assign w_adv    = ex_i_ce & ~ex_i_stall;
    // The instruction right behind a taken transfer is wrong-path and must not act.
    assign w_live   = ex_i_valid & ~r_flush;
    assign w_taken  = w_live & ((ex_i_opcode[OP_BRANCH] & w_cmp) | ex_i_opcode[OP_JAL] | ex_i_opcode[OP_JALR]);
    assign w_wr     = w_live & (ex_i_addr_rd != '0) & |(ex_i_opcode & WR_RD_MASK);

    always_ff @(posedge c_clk or negedge c_rst) begin
        if (!c_rst) begin
            r_valid      <= 1'b0;
            r_result     <= '0;
            r_store_data <= '0;
            r_addr_rd    <= '0;
            r_wr_rd      <= 1'b0;
            r_opcode     <= '0;
            r_funct3     <= '0;
            r_change_pc  <= 1'b0;
            r_next_pc    <= '0;
            r_flush      <= 1'b0;
        end else if (ex_i_flush) begin
            r_valid     <= 1'b0;
            r_wr_rd     <= 1'b0;
            r_change_pc <= 1'b0;
            r_flush     <= 1'b0;
        end else if (w_adv) begin
            r_valid      <= w_live;
            r_result     <= w_result;
            r_store_data <= ex_i_data_rs2;
            r_addr_rd    <= ex_i_addr_rd;
            r_wr_rd      <= w_wr;
            r_opcode     <= ex_i_opcode;
            r_funct3     <= ex_i_funct3;
            r_change_pc  <= w_taken;
            r_flush      <= w_taken;
            if (w_taken) r_next_pc <= w_target;
        end else begin
            r_change_pc <= 1'b0;
            r_flush     <= 1'b0;
        end
    end

    assign ex_o_valid      = r_valid;
    assign ex_o_result     = r_result;
    assign ex_o_store_data = r_store_data;
    assign ex_o_addr_rd    = r_addr_rd;
    assign ex_o_wr_rd      = r_wr_rd;
    assign ex_o_opcode     = r_opcode;
    assign ex_o_funct3     = r_funct3;
    assign ex_o_change_pc  = r_change_pc;
    assign ex_o_next_pc    = r_next_pc;
    assign ex_o_flush      = r_flush;
    assign ex_o_stall      = ex_i_stall | ~ex_i_ce;
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed vector table plus hand-written stall/flush/reset sequences.
module tb_execute_stage;
    localparam logic [10:0] RT = 11'd1, IT = 11'd2, LD = 11'd4, ST = 11'd8, BR = 11'd16;
    localparam logic [10:0] JL = 11'd32, JR = 11'd64, LU = 11'd128, AU = 11'd256;
    localparam logic [13:0] A_ADD = 14'h1, A_SUB = 14'h2, A_SLT = 14'h4, A_SLTU = 14'h8;
    localparam logic [13:0] A_SLL = 14'h80, A_SRA = 14'h200, A_EQ = 14'h400, A_NEQ = 14'h800, A_GEU = 14'h2000;

    typedef struct packed {
        logic [10:0] op;
        logic [13:0] alu;
        logic [31:0] pc, imm, rs1, rs2;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        wr, chg;
        logic [31:0] npc;
    } vec_t;

    logic c_clk = 1'b0, c_rst = 1'b0;
    logic ex_i_ce = 1'b1, ex_i_valid = 1'b0, ex_i_stall = 1'b0, ex_i_flush = 1'b0;
    logic [31:0] ex_i_pc = '0, ex_i_imm = '0, ex_i_data_rs1 = '0, ex_i_data_rs2 = '0;
    logic [10:0] ex_i_opcode = '0;
    logic [13:0] ex_i_alu = '0;
    logic [2:0]  ex_i_funct3 = '0;
    logic [4:0]  ex_i_addr_rd = '0;
    logic        ex_o_valid, ex_o_wr_rd, ex_o_change_pc, ex_o_flush, ex_o_stall;
    logic [31:0] ex_o_result, ex_o_store_data, ex_o_next_pc;
    logic [4:0]  ex_o_addr_rd;
    logic [10:0] ex_o_opcode;
    logic [2:0]  ex_o_funct3;
    int n_chk = 0, n_fail = 0;
    vec_t v [14];

    execute_stage dut (
        .c_clk(c_clk), .c_rst(c_rst), .ex_i_ce(ex_i_ce), .ex_i_valid(ex_i_valid),
        .ex_i_stall(ex_i_stall), .ex_i_flush(ex_i_flush), .ex_i_pc(ex_i_pc),
        .ex_i_opcode(ex_i_opcode), .ex_i_alu(ex_i_alu), .ex_i_funct3(ex_i_funct3),
        .ex_i_imm(ex_i_imm), .ex_i_addr_rd(ex_i_addr_rd), .ex_i_data_rs1(ex_i_data_rs1),
        .ex_i_data_rs2(ex_i_data_rs2), .ex_o_valid(ex_o_valid), .ex_o_result(ex_o_result),
        .ex_o_store_data(ex_o_store_data), .ex_o_addr_rd(ex_o_addr_rd), .ex_o_wr_rd(ex_o_wr_rd),
        .ex_o_opcode(ex_o_opcode), .ex_o_funct3(ex_o_funct3), .ex_o_change_pc(ex_o_change_pc),
        .ex_o_next_pc(ex_o_next_pc), .ex_o_flush(ex_o_flush), .ex_o_stall(ex_o_stall)
    );

    always #5 c_clk = ~c_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [10:0] op, input logic [13:0] alu, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [4:0] rd);
        ex_i_opcode = op; ex_i_alu = alu; ex_i_pc = pc; ex_i_imm = imm;
        ex_i_data_rs1 = rs1; ex_i_data_rs2 = rs2; ex_i_addr_rd = rd; ex_i_valid = 1'b1;
    endtask

    task automatic tick;
        @(posedge c_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            op  alu     pc          imm           rs1           rs2           rd  res           wr chg npc
        v[0]  = '{RT, A_ADD,  32'h0,    32'h0,        32'd5,        32'd7,        5'd3, 32'd12,       1'b1, 1'b0, 32'h0};
        v[1]  = '{IT, A_SRA,  32'h0,    32'd4,        32'h80000000, 32'h0,        5'd4, 32'hF8000000, 1'b1, 1'b0, 32'h0};
        v[2]  = '{RT, A_SLTU, 32'h0,    32'h0,        32'd1,        32'hFFFFFFFF, 5'd5, 32'd1,        1'b1, 1'b0, 32'h0};
        v[3]  = '{RT, A_SLT,  32'h0,    32'h0,        32'd1,        32'hFFFFFFFF, 5'd5, 32'd0,        1'b1, 1'b0, 32'h0};
        v[4]  = '{RT, A_SUB,  32'h0,    32'h0,        32'd3,        32'd5,        5'd6, 32'hFFFFFFFE, 1'b1, 1'b0, 32'h0};
        v[5]  = '{LU, A_ADD,  32'h0,    32'h12345000, 32'h77,       32'h0,        5'd7, 32'h12345000, 1'b1, 1'b0, 32'h0};
        v[6]  = '{AU, A_ADD,  32'h1000, 32'h2000,     32'h55,       32'h0,        5'd8, 32'h3000,     1'b1, 1'b0, 32'h0};
        v[7]  = '{LD, A_ADD,  32'h0,    32'hFFFFFFFC, 32'h100,      32'h0,        5'd9, 32'hFC,       1'b1, 1'b0, 32'h0};
        v[8]  = '{ST, A_ADD,  32'h0,    32'd8,        32'h200,      32'hAB,       5'd9, 32'h208,      1'b0, 1'b0, 32'h0};
        v[9]  = '{BR, A_EQ,   32'h100,  32'h20,       32'd3,        32'd3,        5'd0, 32'd1,        1'b0, 1'b1, 32'h120};
        v[10] = '{BR, A_NEQ,  32'h100,  32'h20,       32'd3,        32'd3,        5'd0, 32'd0,        1'b0, 1'b0, 32'h0};
        v[11] = '{JR, A_ADD,  32'h40,   32'd2,        32'h203,      32'h0,        5'd1, 32'h44,       1'b1, 1'b1, 32'h204};
        v[12] = '{JL, A_ADD,  32'h80,   32'h10,       32'h0,        32'h0,        5'd0, 32'h84,       1'b0, 1'b1, 32'h90};
        v[13] = '{IT, A_SLL,  32'h0,    32'h25,       32'd1,        32'h0,        5'd2, 32'h20,       1'b1, 1'b0, 32'h0};

        drive(RT, A_ADD, 32'h10, 32'h4, 32'd1, 32'd2, 5'd3);
        repeat (2) tick();
        chk("rst_valid", ex_o_valid, 0);
        chk("rst_result", ex_o_result, 0);
        chk("rst_wr", ex_o_wr_rd, 0);
        chk("rst_chg", ex_o_change_pc, 0);
        chk("rst_flush", ex_o_flush, 0);
        chk("rst_npc", ex_o_next_pc, 0);
        chk("rst_sdata", ex_o_store_data, 0);
        ex_i_valid = 1'b0;
        c_rst = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            drive(v[i].op, v[i].alu, v[i].pc, v[i].imm, v[i].rs1, v[i].rs2, v[i].rd);
            tick();
            chk($sformatf("v%0d_valid", i), ex_o_valid, 1);
            chk($sformatf("v%0d_result", i), ex_o_result, v[i].res);
            chk($sformatf("v%0d_wr", i), ex_o_wr_rd, v[i].wr);
            chk($sformatf("v%0d_chg", i), ex_o_change_pc, v[i].chg);
            chk($sformatf("v%0d_flush", i), ex_o_flush, v[i].chg);
            chk($sformatf("v%0d_sdata", i), ex_o_store_data, v[i].rs2);
            chk($sformatf("v%0d_op", i), 32'(ex_o_opcode), 32'(v[i].op));
            if (v[i].chg) chk($sformatf("v%0d_npc", i), ex_o_next_pc, v[i].npc);
            ex_i_valid = 1'b0;
            tick();
            chk($sformatf("v%0d_chg_clr", i), ex_o_change_pc, 0);
        end

        // Stall freezes outputs
        drive(RT, A_ADD, 32'h0, 32'h0, 32'd1, 32'd2, 5'd2);
        tick();
        chk("st_res0", ex_o_result, 3);
        ex_i_stall = 1'b1;
        drive(RT, A_SUB, 32'h0, 32'h0, 32'd9, 32'd4, 5'd7);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_res", ex_o_result, 3);
            chk("st_valid", ex_o_valid, 1);
            chk("st_rd", 32'(ex_o_addr_rd), 2);
        end
        chk("st_req", ex_o_stall, 1);
        ex_i_stall = 1'b0;
        ex_i_valid = 1'b0;
        tick();
        chk("st_req_clr", ex_o_stall, 0);

        // Redirect pulse not repeated under stall; flush wins over stall
        drive(BR, A_EQ, 32'h100, 32'h20, 32'd3, 32'd3, 5'd0);
        tick();
        chk("sb_chg", ex_o_change_pc, 1);
        ex_i_stall = 1'b1;
        ex_i_valid = 1'b0;
        tick();
        chk("sb_chg1", ex_o_change_pc, 0);
        chk("sb_flush1", ex_o_flush, 0);
        chk("sb_npc", ex_o_next_pc, 32'h120);
        chk("sb_valid", ex_o_valid, 1);
        tick();
        chk("sb_chg2", ex_o_change_pc, 0);
        ex_i_flush = 1'b1;
        tick();
        chk("fl_valid", ex_o_valid, 0);
        chk("fl_wr", ex_o_wr_rd, 0);
        ex_i_flush = 1'b0;
        ex_i_stall = 1'b0;

        // Wrong-path squash behind taken branch
        drive(BR, A_EQ, 32'h100, 32'h20, 32'd3, 32'd3, 5'd0);
        tick();
        chk("sq_chg", ex_o_change_pc, 1);
        drive(RT, A_ADD, 32'h0, 32'h0, 32'd5, 32'd7, 5'd3);
        tick();
        chk("sq_valid", ex_o_valid, 0);
        chk("sq_wr", ex_o_wr_rd, 0);
        chk("sq_chg2", ex_o_change_pc, 0);

        // ce=0 behaves as stall
        ex_i_ce = 1'b0;
        drive(RT, A_ADD, 32'h0, 32'h0, 32'd1, 32'd1, 5'd4);
        tick();
        chk("ce_valid", ex_o_valid, 0);
        chk("ce_req", ex_o_stall, 1);
        ex_i_ce = 1'b1;
        tick();
        chk("ce_res", ex_o_result, 2);
        chk("ce_valid2", ex_o_valid, 1);

        // Asynchronous reset mid-branch
        drive(BR, A_EQ, 32'h100, 32'h20, 32'd3, 32'd3, 5'd0);
        tick();
        chk("ar_chg", ex_o_change_pc, 1);
        #2;
        c_rst = 1'b0;
        #1;
        chk("ar_chg0", ex_o_change_pc, 0);
        chk("ar_flush0", ex_o_flush, 0);
        chk("ar_npc0", ex_o_next_pc, 0);
        chk("ar_res0", ex_o_result, 0);
        chk("ar_valid0", ex_o_valid, 0);
        ex_i_valid = 1'b0;
        @(negedge c_clk);
        c_rst = 1'b1;
        tick();
        chk("ar_chg_rel", ex_o_change_pc, 0);
        chk("ar_valid_rel", ex_o_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 5-stage RV32I pipeline, directly downstream of the fetch/decode pair. Consumes decoded opcode, ALU operation, funct3, immediate, register addresses, register-file read data and the instruction PC. Computes the ALU result, branch/jump decision and target, and store data. Presents everything through a registered EX/MEM boundary with valid/stall/flush control, and raises a PC-redirect and flush request toward fetch and decode on taken control transfers.

## Interface
- `DWIDTH`, 32, data/operand width
- `PC_WIDTH`, 32, program counter width
- `AWIDTH`, 5, register address width
- `FUNCT_WIDTH`, 3, funct3 width
- `c_clk` in 1: single clock, all state on rising edge
- `c_rst` in 1: asynchronous, active-low reset
- `ex_i_ce` in 1: stage enable; 0 freezes the stage exactly like stall
- `ex_i_valid` in 1: decode output holds a real instruction
- `ex_i_stall` in 1: downstream (memory stage) cannot accept
- `ex_i_flush` in 1: external flush (trap/redirect from later stage)
- `ex_i_pc` in PC_WIDTH: PC of the instruction
- `ex_i_opcode` in `OPCODE_WIDTH`: one-hot opcode class from decode
- `ex_i_alu` in `ALU_WIDTH`: one-hot ALU operation from decode
- `ex_i_funct3` in FUNCT_WIDTH: funct3 passthrough
- `ex_i_imm` in DWIDTH: sign-extended immediate
- `ex_i_addr_rd` in AWIDTH: destination register address
- `ex_i_data_rs1`, `ex_i_data_rs2` in DWIDTH: register-file read data
- `ex_o_valid` out 1: registered outputs hold a valid instruction
- `ex_o_result` out DWIDTH: ALU result / link address / load-store effective address
- `ex_o_store_data` out DWIDTH: rs2 data for stores
- `ex_o_addr_rd` out AWIDTH: destination register
- `ex_o_wr_rd` out 1: instruction writes rd (rd != 0 and class writes)
- `ex_o_opcode` out `OPCODE_WIDTH`, `ex_o_funct3` out FUNCT_WIDTH: passthrough
- `ex_o_change_pc` out 1: one-cycle redirect pulse
- `ex_o_next_pc` out PC_WIDTH: redirect target
- `ex_o_flush` out 1: flush request to fetch and decode, same cycle as `ex_o_change_pc`
- `ex_o_stall` out 1: stall request upstream = `ex_i_stall | ~ex_i_ce`

## Operation
- Operand A: PC for AUIPC/JAL, else rs1. Operand B: rs2 for RTYPE/BRANCH, else imm.
- ALU ops: ADD, SUB, SLT, SLTU, XOR, OR, AND, SLL, SRL, SRA, EQ, NEQ, GE, GEU. Shifts use B[4:0]. Arithmetic wraps modulo 2^32. SLT/GE are signed; SLTU/GEU are unsigned. Compares return 0/1.
- Result mux:
  - LUI → imm
  - JAL/JALR → PC+4
  - LOAD/STORE → rs1+imm
  - otherwise → ALU output
- Branch taken when BRANCH and ALU compare = 1.
- Targets:
  - branch/JAL → PC+imm
  - JALR → (rs1+imm) with bit 0 cleared
- `ex_o_wr_rd` = 1 for RTYPE, ITYPE, LOAD, JAL, JALR, LUI, AUIPC when rd != 0; otherwise 0.
- SYSTEM and FENCE pass through as valid no-ops with `ex_o_wr_rd` = 0.

## Timing
- Reset: every output is 0, including `ex_o_next_pc`. Release is asynchronous-assert, synchronous-deassert at the edge.
- Latency: 1 cycle, input sampled at edge N and visible after edge N.
- Advance condition: `ex_i_ce & ~ex_i_stall`. On advance, registers load the computed values, and `ex_o_valid` = `ex_i_valid & ~ex_i_flush & ~ex_o_flush`.
- Hold: when not advancing, all registers keep their value. `ex_o_change_pc` and `ex_o_flush` clear after one cycle, so a redirect is never repeated.
- Taken branch/jump on advance: `ex_o_change_pc` = `ex_o_flush` = 1 for exactly one cycle, and `ex_o_next_pc` is loaded. The next instruction arriving while `ex_o_flush` = 1 is a wrong-path instruction and is squashed (valid = 0).
- Flush: `ex_i_flush` has priority over stall. It clears `ex_o_valid`, `ex_o_wr_rd`, `ex_o_change_pc` and `ex_o_flush` at the next edge even while stalled.
- Invalid input (`ex_i_valid` = 0): no redirect and no write.
- Reset mid-operation: all state cleared immediately, with no redirect pending.

## Structure
- Shared header (already used by decode) holds `OPCODE_WIDTH` = 11 with one-hot indices RTYPE, ITYPE, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, FENCE. It also holds `ALU_WIDTH` = 14 with the ALU op indices in the order listed above.
- One sub-module, `alu`: purely combinational operand-to-result plus compare flag. The stage wrapper holds the mux, target logic and the EX/MEM register.

## Test plan
- Reset 2 cycles, then ADD rs1=5, rs2=7 valid → one cycle later `ex_o_result`=12, `ex_o_valid`=1, `ex_o_wr_rd`=1; all outputs 0 during reset.
- SRA rs1=0x80000000, imm=4 ITYPE → 0xF8000000. SLTU 1 vs 0xFFFFFFFF → 1. SLT same operands → 0.
- BEQ pc=0x100, rs1=rs2=3, imm=0x20 → `ex_o_change_pc`=`ex_o_flush`=1 for one cycle, `ex_o_next_pc`=0x120; the following valid instruction emerges with `ex_o_valid`=0.
- JALR pc=0x40, rs1=0x203, imm=2, rd=1 → result 0x44, next_pc 0x204. JAL with rd=0 → `ex_o_wr_rd`=0.
- Stall 3 cycles after issuing ADD → outputs frozen, single change_pc pulse not repeated; flush asserted during the stall → `ex_o_valid`=0 next edge.
- Assert `c_rst`=0 mid-branch → all outputs 0 asynchronously, no redirect after release.
